// File: rtl/instr_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// instr_cycle_sequencer
//
// Multi-cycle control FSM for the MIPS-subset datapath. Each instruction runs
// through FETCH, DECODE, EXECUTE and, if needed, MEMORY and WRITEBACK. The FSM
// issues a one-cycle strobe for each phase and a pc_update strobe in the last
// phase of every instruction. The MEMORY phase waits on the data-memory
// mem_ready handshake. The block also provides run, single-step and halt
// control.
//
// Optional feature:
//   SEQ_PERF_CNT_EN  When defined, builds the retired-instruction and active-
//                    cycle counters. When undefined, both count outputs are
//                    tied to 0 and no counter flops are built.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   run          level: execute continuously
//   step         pulse: execute one instruction from IDLE
//   halt_req     pulse: stop after the current instruction completes
//   opcode       decoder opcode, sampled in DECODE
//   reg_write    decoder RegWrite, sampled in DECODE
//   mem_read     decoder MemRead, sampled in DECODE
//   mem_write    decoder MemWrite, sampled in DECODE
//   mem_ready    data memory has completed the access
//   ir_load      FETCH strobe
//   dec_en       DECODE strobe
//   alu_en       EXECUTE strobe
//   mem_req      held high through MEMORY
//   mem_we       store qualifier for mem_req
//   rf_we        WRITEBACK register-file write
//   pc_update    advance PC; one cycle, last phase of each instruction
//   state        current state encoding
//   halted       FSM is in HALT
//   mem_fault    sticky memory-timeout flag
//   instr_count  retired instructions (SEQ_PERF_CNT_EN)
//   cycle_count  cycles spent in FETCH..WRITEBACK (SEQ_PERF_CNT_EN)
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for run or step
// FETCH | load the instruction register
// DECODE| read registers and latch decoder flags; trap the HALT opcode
// EXEC  | ALU phase; beq/j complete here
// MEMORY| data access; wait on mem_ready, or time out into HALT
// WB    | register-file write; the instruction completes
// HALT  | stopped; only reset leaves this state
// ---------------------------------------------------------------------------
module instr_cycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        halt_req,
  input  logic [5:0]  opcode,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_ready,
  output logic        ir_load,
  output logic        dec_en,
  output logic        alu_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_we,
  output logic        pc_update,
  output logic [2:0]  state,
  output logic        halted,
  output logic        mem_fault,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  // Value of the wait counter during the last MEMORY cycle that may still
  // see mem_ready. If mem_ready is still low in that cycle, the FSM faults.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     st;
  logic       step_mode;
  logic       halt_pend;
  logic       rw_q;
  logic       mr_q;
  logic       mw_q;
  logic [7:0] wait_cnt;
  logic       stop;
  state_t     done_next;

  // A halt_req that arrives in the completion cycle itself still stops the FSM.
  assign stop      = step_mode | halt_pend | halt_req | ~run;
  assign done_next = stop ? S_IDLE : S_FETCH;

  // Moore decodes of the state register. The one exception is the store
  // completion, which is qualified by mem_ready in the same cycle.
  always_comb begin
    ir_load   = 1'b0;
    dec_en    = 1'b0;
    alu_en    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rf_we     = 1'b0;
    pc_update = 1'b0;
    case (st)
      S_FETCH:     ir_load = 1'b1;
      S_DECODE:    dec_en  = 1'b1;
      S_EXECUTE: begin
        alu_en    = 1'b1;
        pc_update = ~(mr_q | mw_q) & ~rw_q;
      end
      S_MEMORY: begin
        mem_req   = 1'b1;
        mem_we    = mw_q;
        pc_update = mem_ready & ~mr_q;
      end
      S_WRITEBACK: begin
        rf_we     = 1'b1;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign state  = st;
  assign halted = (st == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_IDLE;
      step_mode <= 1'b0;
      halt_pend <= 1'b0;
      rw_q      <= 1'b0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      if (halt_req && st != S_IDLE) halt_pend <= 1'b1;

      case (st)
        S_IDLE: begin
          if (run) begin
            st        <= S_FETCH;
            step_mode <= 1'b0;
          end else if (step) begin
            st        <= S_FETCH;
            step_mode <= 1'b1;
          end
        end
        S_FETCH: st <= S_DECODE;
        // The HALT decision uses the live opcode, so only the control flags
        // need to be held for the later phases.
        S_DECODE: begin
          rw_q <= reg_write;
          mr_q <= mem_read;
          mw_q <= mem_write;
          st   <= (opcode == HALT_OPCODE) ? S_HALT : S_EXECUTE;
        end
        S_EXECUTE: begin
          wait_cnt <= '0;
          if (mr_q | mw_q)  st <= S_MEMORY;
          else if (rw_q)    st <= S_WRITEBACK;
          else              st <= done_next;
        end
        S_MEMORY: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            st       <= mr_q ? S_WRITEBACK : done_next;
          end else if (wait_cnt == WAIT_LAST) begin
            mem_fault <= 1'b1;
            st        <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WRITEBACK: st <= done_next;
        S_HALT:      st <= S_HALT;
        default:     st <= S_IDLE;
      endcase

      // Entering IDLE after a completion clears both stop reasons. This also
      // overrides the halt_req latch above.
      if (pc_update && stop) begin
        step_mode <= 1'b0;
        halt_pend <= 1'b0;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instr_q;
  logic [31:0] cycle_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      if (pc_update) instr_q <= instr_q + 32'd1;
      if (st >= S_FETCH && st <= S_WRITEBACK) cycle_q <= cycle_q + 32'd1;
    end
  end

  assign instr_count = instr_q;
  assign cycle_count = cycle_q;
`else
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
module tb_instr_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        step;
  logic        halt_req;
  logic [5:0]  opcode;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready;
  logic        ir_load;
  logic        dec_en;
  logic        alu_en;
  logic        mem_req;
  logic        mem_we;
  logic        rf_we;
  logic        pc_update;
  logic [2:0]  state;
  logic        halted;
  logic        mem_fault;
  logic [31:0] instr_count;
  logic [31:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Strobe order: ir_load dec_en alu_en mem_req mem_we rf_we pc_update
  localparam logic [6:0] S0   = 7'b0000000;
  localparam logic [6:0] SF   = 7'b1000000;
  localparam logic [6:0] SD   = 7'b0100000;
  localparam logic [6:0] SE   = 7'b0010000;
  localparam logic [6:0] SEP  = 7'b0010001;
  localparam logic [6:0] SML  = 7'b0001000;
  localparam logic [6:0] SMS  = 7'b0001100;
  localparam logic [6:0] SMSP = 7'b0001101;
  localparam logic [6:0] SWB  = 7'b0000011;

  instr_cycle_sequencer #(.MEM_TIMEOUT(15), .HALT_OPCODE(6'b111111)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .opcode(opcode), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_ready(mem_ready), .ir_load(ir_load),
    .dec_en(dec_en), .alu_en(alu_en), .mem_req(mem_req), .mem_we(mem_we),
    .rf_we(rf_we), .pc_update(pc_update), .state(state), .halted(halted),
    .mem_fault(mem_fault), .instr_count(instr_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  logic [11:0] obs;
  assign obs = {state, ir_load, dec_en, alu_en, mem_req, mem_we, rf_we, pc_update,
                halted, mem_fault};

  function automatic logic [13:0] dv(input int rst, input int rn, input int stp,
                                     input int hr, input int rdy, input logic [5:0] op,
                                     input int rw, input int mr, input int mw);
    return {1'(rst), 1'(rn), 1'(stp), 1'(hr), 1'(rdy), op, 1'(rw), 1'(mr), 1'(mw)};
  endfunction

  function automatic logic [11:0] ev(input int st, input logic [6:0] s, input int h,
                                     input int f);
    return {3'(st), s, 1'(h), 1'(f)};
  endfunction

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic apply(input logic [13:0] v);
    @(posedge clk);
    #1;
    {reset, run, step, halt_req, mem_ready, opcode, reg_write, mem_read, mem_write} = v;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
    opcode = 6'd0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs !== 12'h000) begin
      n_bad++; $display("FAIL reset_outputs: got %h want %h", obs, 12'h000);
    end
    n_cmp++;
    if (instr_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_instr_count: got %0d want 0", instr_count);
    end
    n_cmp++;
    if (cycle_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_cycle_count: got %0d want 0", cycle_count);
    end
  endtask

  task automatic test_alu();
    logic [13:0] d[$];
    logic [11:0] e[$];
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(1,SF,0,0));
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(2,SD,0,0));
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(3,SE,0,0));
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(5,SWB,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,1,0,0)); e.push_back(ev(1,SF,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,1,0,0)); e.push_back(ev(2,SD,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,1,0,0)); e.push_back(ev(3,SE,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,1,0,0)); e.push_back(ev(5,SWB,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    for (int i = 0; i < d.size(); i++) begin
      apply(d[i]);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL alu cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [13:0] d[$];
    logic [11:0] e[$];
    d.push_back(dv(0,1,0,0,0,6'h23,1,1,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,1,0,0,0,6'h23,1,1,0)); e.push_back(ev(1,SF,0,0));
    d.push_back(dv(0,1,0,0,0,6'h23,1,1,0)); e.push_back(ev(2,SD,0,0));
    d.push_back(dv(0,1,0,0,0,6'h23,1,1,0)); e.push_back(ev(3,SE,0,0));
    d.push_back(dv(0,1,0,0,0,6'h23,1,1,0)); e.push_back(ev(4,SML,0,0));
    d.push_back(dv(0,1,0,0,0,6'h23,1,1,0)); e.push_back(ev(4,SML,0,0));
    d.push_back(dv(0,1,0,0,1,6'h23,1,1,0)); e.push_back(ev(4,SML,0,0));
    d.push_back(dv(0,0,0,0,0,6'h23,1,1,0)); e.push_back(ev(5,SWB,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    for (int i = 0; i < d.size(); i++) begin
      apply(d[i]);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL lw_wait cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_step_store();
    logic [13:0] d[$];
    logic [11:0] e[$];
    d.push_back(dv(1,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(1,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,0,1,0,0,6'h2B,0,0,1)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,0,0,0,0,6'h2B,0,0,1)); e.push_back(ev(1,SF,0,0));
    d.push_back(dv(0,0,0,0,0,6'h2B,0,0,1)); e.push_back(ev(2,SD,0,0));
    d.push_back(dv(0,0,0,0,0,6'h2B,0,0,1)); e.push_back(ev(3,SE,0,0));
    d.push_back(dv(0,0,0,0,1,6'h2B,0,0,1)); e.push_back(ev(4,SMSP,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    for (int i = 0; i < d.size(); i++) begin
      apply(d[i]);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL step_store cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
    n_cmp++;
    if (instr_count !== (PERF ? 32'd1 : 32'd0)) begin
      n_bad++; $display("FAIL step_instr_count: got %0d want %0d", instr_count, PERF ? 1 : 0);
    end
    n_cmp++;
    if (cycle_count !== (PERF ? 32'd4 : 32'd0)) begin
      n_bad++; $display("FAIL step_cycle_count: got %0d want %0d", cycle_count, PERF ? 4 : 0);
    end
  endtask

  task automatic test_halt_in_execute();
    logic [13:0] d[$];
    logic [11:0] e[$];
    d.push_back(dv(0,1,0,0,0,6'h04,0,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,1,0,0,0,6'h04,0,0,0)); e.push_back(ev(1,SF,0,0));
    d.push_back(dv(0,1,0,0,0,6'h04,0,0,0)); e.push_back(ev(2,SD,0,0));
    d.push_back(dv(0,1,0,1,0,6'h04,0,0,0)); e.push_back(ev(3,SEP,0,0));
    d.push_back(dv(0,0,0,0,0,6'h04,0,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,0,0,0,0,6'h04,0,0,0)); e.push_back(ev(0,S0,0,0));
    for (int i = 0; i < d.size(); i++) begin
      apply(d[i]);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL halt_exec cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_halt_pending();
    logic [13:0] d[$];
    logic [11:0] e[$];
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,1,0,1,0,6'h00,1,0,0)); e.push_back(ev(1,SF,0,0));
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(2,SD,0,0));
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(3,SE,0,0));
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(5,SWB,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,1,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    for (int i = 0; i < d.size(); i++) begin
      apply(d[i]);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL halt_pending cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  // Starting with run and step both high also confirms that run wins, so no
  // single-step stop happens after the first instruction.
  task automatic test_back_to_back();
    logic [13:0] d[$];
    logic [11:0] e[$];
    d.push_back(dv(0,1,1,0,0,6'h04,0,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,1,0,0,0,6'h04,0,0,0)); e.push_back(ev(1,SF,0,0));
    d.push_back(dv(0,1,0,0,0,6'h04,0,0,0)); e.push_back(ev(2,SD,0,0));
    d.push_back(dv(0,1,0,0,0,6'h04,0,0,0)); e.push_back(ev(3,SEP,0,0));
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(1,SF,0,0));
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(2,SD,0,0));
    d.push_back(dv(0,1,0,0,0,6'h00,1,0,0)); e.push_back(ev(3,SE,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,1,0,0)); e.push_back(ev(5,SWB,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    for (int i = 0; i < d.size(); i++) begin
      apply(d[i]);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL back_to_back cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_mem_timeout();
    logic [13:0] d[$];
    logic [11:0] e[$];
    d.push_back(dv(1,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(1,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,1,0,0,0,6'h23,1,1,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,1,0,0,0,6'h23,1,1,0)); e.push_back(ev(1,SF,0,0));
    d.push_back(dv(0,1,0,0,0,6'h23,1,1,0)); e.push_back(ev(2,SD,0,0));
    d.push_back(dv(0,1,0,0,0,6'h23,1,1,0)); e.push_back(ev(3,SE,0,0));
    for (int k = 0; k < 15; k++) begin
      d.push_back(dv(0,1,0,0,0,6'h23,1,1,0)); e.push_back(ev(4,SML,0,0));
    end
    d.push_back(dv(0,1,1,0,1,6'h23,1,1,0)); e.push_back(ev(6,S0,1,1));
    d.push_back(dv(0,1,0,0,1,6'h23,1,1,0)); e.push_back(ev(6,S0,1,1));
    d.push_back(dv(1,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(6,S0,1,1));
    d.push_back(dv(0,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    for (int i = 0; i < d.size(); i++) begin
      apply(d[i]);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL mem_timeout cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
    n_cmp++;
    if (instr_count !== 32'd0) begin
      n_bad++; $display("FAIL timeout_instr_count: got %0d want 0", instr_count);
    end
  endtask

  task automatic test_halt_opcode();
    logic [13:0] d[$];
    logic [11:0] e[$];
    d.push_back(dv(0,1,0,0,0,6'h3F,1,0,0)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,1,0,0,0,6'h3F,1,0,0)); e.push_back(ev(1,SF,0,0));
    d.push_back(dv(0,1,0,0,0,6'h3F,1,0,0)); e.push_back(ev(2,SD,0,0));
    d.push_back(dv(0,1,1,0,1,6'h3F,1,0,0)); e.push_back(ev(6,S0,1,0));
    d.push_back(dv(0,1,0,0,0,6'h3F,1,0,0)); e.push_back(ev(6,S0,1,0));
    d.push_back(dv(1,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(6,S0,1,0));
    d.push_back(dv(0,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    for (int i = 0; i < d.size(); i++) begin
      apply(d[i]);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL halt_opcode cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
    n_cmp++;
    if (instr_count !== 32'd0) begin
      n_bad++; $display("FAIL halt_opcode_instr_count: got %0d want 0", instr_count);
    end
  endtask

  task automatic test_reset_in_memory();
    logic [13:0] d[$];
    logic [11:0] e[$];
    d.push_back(dv(0,1,0,0,0,6'h2B,0,0,1)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,1,0,0,0,6'h2B,0,0,1)); e.push_back(ev(1,SF,0,0));
    d.push_back(dv(0,1,0,0,0,6'h2B,0,0,1)); e.push_back(ev(2,SD,0,0));
    d.push_back(dv(0,1,0,0,0,6'h2B,0,0,1)); e.push_back(ev(3,SE,0,0));
    d.push_back(dv(1,1,0,0,0,6'h2B,0,0,1)); e.push_back(ev(4,SMS,0,0));
    d.push_back(dv(0,0,0,0,1,6'h2B,0,0,1)); e.push_back(ev(0,S0,0,0));
    d.push_back(dv(0,0,0,0,0,6'h00,0,0,0)); e.push_back(ev(0,S0,0,0));
    for (int i = 0; i < d.size(); i++) begin
      apply(d[i]);
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++; $display("FAIL reset_in_memory cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
    n_cmp++;
    if (instr_count !== 32'd0 || cycle_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_in_memory_counts: got %0d/%0d want 0/0", instr_count, cycle_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw_wait();
    test_step_store();
    test_halt_in_execute();
    test_halt_pending();
    test_back_to_back();
    test_mem_timeout();
    test_halt_opcode();
    test_reset_in_memory();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
